// File: rtl/gvsp_pkg.sv
// Shared GVSP constants and header layout used by the image packetizer and depacketizer.
package gvsp_pkg;

   localparam logic [7:0]  FMT_LEADER    = 8'd1;
   localparam logic [7:0]  FMT_TRAILER   = 8'd2;
   localparam logic [7:0]  FMT_DATA      = 8'd3;
   localparam logic [15:0] PAYLOAD_IMAGE = 16'd1;
   localparam int          HDR_LEN       = 8;

   localparam int ERR_SHORT = 0;
   localparam int ERR_PID   = 1;
   localparam int ERR_BLK   = 2;
   localparam int ERR_FMT   = 3;

   // Leader byte offsets, counted from the start of the packet
   localparam int OFF_PAYLOAD_TYPE = 10;
   localparam int OFF_TIMESTAMP    = 12;
   localparam int OFF_PIXEL_TYPE   = 20;
   localparam int OFF_SIZE_X_LO16  = 26;
   localparam int OFF_SIZE_Y_LO16  = 30;

   typedef enum logic [2:0] {
      ST_HDR     = 3'd0,
      ST_LEADER  = 3'd1,
      ST_DATA    = 3'd2,
      ST_TRAILER = 3'd3,
      ST_DROP    = 3'd4
   } rx_state_t;

   typedef struct packed {
      logic [15:0] status;
      logic [15:0] blk;
      logic [7:0]  format;
      logic [23:0] pid;
   } gvsp_hdr_t;

   function automatic logic in_field(input logic [15:0] off, input int base, input int len);
      return (int'(off) >= base) && (int'(off) < (base + len));
   endfunction

endpackage

// File: rtl/gvsp_byte_packer.sv
// Packs bytes little-endian into DATA_BITS words behind a single output register.
// The input stalls only when a word is complete and the output register is still held.
module gvsp_byte_packer #(
   parameter int DATA_BITS = 32
)(
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [7:0]           byte_data,
   input  logic                 byte_valid,
   input  logic                 byte_last,
   input  logic                 byte_sof,
   output logic                 byte_ready,
   output logic                 word_load,
   output logic [DATA_BITS-1:0] m_tdata,
   output logic                 m_tvalid,
   output logic                 m_tlast,
   output logic                 m_tuser,
   input  logic                 m_tready
);

   localparam int         NB       = DATA_BITS / 8;
   localparam logic [3:0] LAST_IDX = 4'(NB - 1);

   logic [DATA_BITS-1:0] acc_r;
   logic [DATA_BITS-1:0] word_s;
   logic [3:0]           cnt_r;
   logic                 word_done_s;
   logic                 accept_s;

   // Merge the incoming byte into the partial word and decide whether it completes it
   always_comb begin
      word_s = acc_r;
      for (int i = 0; i < NB; i++) begin
         if (cnt_r == 4'(i)) begin
            word_s[i*8 +: 8] = byte_data;
         end else begin
            word_s[i*8 +: 8] = acc_r[i*8 +: 8];
         end
      end
      word_done_s = (cnt_r == LAST_IDX) || byte_last;
      byte_ready  = !(m_tvalid && !m_tready && word_done_s);
      accept_s    = byte_valid && byte_ready;
      word_load   = accept_s && word_done_s;
   end

   // Accumulator is cleared after every emitted word, so a short tail word is zero-padded
   always_ff @(posedge aclk) begin
      if (areset) begin
         acc_r <= '0;
         cnt_r <= 4'd0;
      end else if (accept_s) begin
         if (word_done_s) begin
            acc_r <= '0;
            cnt_r <= 4'd0;
         end else begin
            acc_r <= word_s;
            cnt_r <= cnt_r + 4'd1;
         end
      end
   end

   // Output register
   always_ff @(posedge aclk) begin
      if (areset) begin
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tuser  <= 1'b0;
      end else if (word_load) begin
         m_tdata  <= word_s;
         m_tvalid <= 1'b1;
         m_tlast  <= byte_last;
         m_tuser  <= byte_sof;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tuser  <= 1'b0;
      end
   end

endmodule

// File: rtl/gvsp_image_rx.sv
// GVSP image depacketizer: parses leader/data/trailer packets from a byte stream,
// emits packed pixel words, latches leader metadata and flags protocol errors.
module gvsp_image_rx
   import gvsp_pkg::*;
#(
   parameter int DATA_BITS   = 32,
   parameter int LEADER_LEN  = 44,
   parameter int TRAILER_LEN = 16
)(
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   output logic [DATA_BITS-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tuser,
   input  logic                 m_axis_tready,
   output logic [15:0]          hsize,
   output logic [15:0]          vsize,
   output logic [63:0]          timestamp,
   output logic [31:0]          pixel_type,
   output logic [15:0]          block_id,
   output logic                 meta_valid,
   output logic                 frame_done,
   output logic                 err,
   output logic [3:0]           err_code
);

   localparam logic [15:0] HDR_LAST     = 16'(HDR_LEN - 1);
   localparam logic [15:0] LEADER_LAST  = 16'(LEADER_LEN - 1);
   localparam logic [15:0] TRAILER_LAST = 16'(TRAILER_LEN - 1);

   rx_state_t   state_r;
   rx_state_t   state_s;
   logic [15:0] off_r;
   logic [55:0] hdr_r;
   gvsp_hdr_t   hdr_s;
   logic [23:0] exp_pid_r;
   logic        in_block_r;
   logic        sof_pending_r;
   logic        beat_s;
   logic        hdr_end_s;
   logic        blk_ok_s;
   logic [3:0]  code_s;
   logic        meta_s;
   logic        done_s;
   logic        accept_pkt_s;
   logic        leader_start_s;
   logic        block_clr_s;
   logic        pk_valid_s;
   logic        pk_ready_s;
   logic        pk_load_s;

   // The eighth header byte is still on the bus when the header is dispatched
   assign hdr_s         = gvsp_hdr_t'({hdr_r, s_axis_tdata});
   assign beat_s        = s_axis_tvalid && s_axis_tready;
   assign hdr_end_s     = (state_r == ST_HDR) && (off_r == HDR_LAST);
   assign blk_ok_s      = in_block_r && (hdr_s.blk == block_id);
   assign pk_valid_s    = s_axis_tvalid && (state_r == ST_DATA);
   assign s_axis_tready = (state_r == ST_DATA) ? pk_ready_s : 1'b1;

   // State register
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r <= ST_HDR;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      if (beat_s) begin
         case (state_r)
            ST_HDR: begin
               if (s_axis_tlast || !hdr_end_s) begin
                  state_s = ST_HDR;
               end else if (hdr_s.status != 16'd0) begin
                  state_s = ST_DROP;
               end else if (hdr_s.format == FMT_LEADER) begin
                  state_s = ST_LEADER;
               end else if (hdr_s.format == FMT_DATA) begin
                  state_s = blk_ok_s ? ST_DATA : ST_DROP;
               end else if (hdr_s.format == FMT_TRAILER) begin
                  state_s = blk_ok_s ? ST_TRAILER : ST_DROP;
               end else begin
                  state_s = ST_DROP;
               end
            end
            ST_LEADER: begin
               if (s_axis_tlast) begin
                  state_s = ST_HDR;
               end else if (off_r == LEADER_LAST) begin
                  state_s = ST_DROP;
               end else begin
                  state_s = ST_LEADER;
               end
            end
            ST_TRAILER: begin
               if (s_axis_tlast) begin
                  state_s = ST_HDR;
               end else if (off_r == TRAILER_LAST) begin
                  state_s = ST_DROP;
               end else begin
                  state_s = ST_TRAILER;
               end
            end
            ST_DATA, ST_DROP: begin
               state_s = s_axis_tlast ? ST_HDR : state_r;
            end
            default: state_s = ST_HDR;
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Per-byte events: error bits, metadata/frame completion, block bookkeeping
   always_comb begin
      code_s         = 4'd0;
      meta_s         = 1'b0;
      done_s         = 1'b0;
      accept_pkt_s   = 1'b0;
      leader_start_s = 1'b0;
      block_clr_s    = 1'b0;
      if (beat_s) begin
         case (state_r)
            ST_HDR: begin
               if (s_axis_tlast) begin
                  code_s[ERR_SHORT] = 1'b1;
               end else if (!hdr_end_s) begin
                  code_s = 4'd0;
               end else if (hdr_s.status != 16'd0) begin
                  code_s[ERR_FMT] = 1'b1;
               end else if (hdr_s.format == FMT_LEADER) begin
                  // A leader inside an open block means the trailer went missing
                  code_s[ERR_SHORT] = in_block_r;
                  code_s[ERR_PID]   = (hdr_s.pid != 24'd0);
                  leader_start_s    = 1'b1;
                  accept_pkt_s      = 1'b1;
               end else if ((hdr_s.format == FMT_DATA) || (hdr_s.format == FMT_TRAILER)) begin
                  if (blk_ok_s) begin
                     code_s[ERR_PID] = (hdr_s.pid != exp_pid_r);
                     accept_pkt_s    = 1'b1;
                  end else begin
                     code_s[ERR_BLK] = 1'b1;
                  end
               end else begin
                  code_s[ERR_FMT] = 1'b1;
               end
            end
            ST_LEADER: begin
               if (off_r == LEADER_LAST) begin
                  meta_s = 1'b1;
               end else if (s_axis_tlast) begin
                  code_s[ERR_SHORT] = 1'b1;
                  block_clr_s       = 1'b1;
               end else begin
                  meta_s = 1'b0;
               end
            end
            ST_TRAILER: begin
               if (off_r == TRAILER_LAST) begin
                  done_s      = 1'b1;
                  block_clr_s = 1'b1;
               end else if (s_axis_tlast) begin
                  code_s[ERR_SHORT] = 1'b1;
                  block_clr_s       = 1'b1;
               end else begin
                  done_s = 1'b0;
               end
            end
            default: code_s = 4'd0;
         endcase
      end else begin
         code_s = 4'd0;
      end
   end

   // Parser registers, metadata capture and status pulses
   always_ff @(posedge aclk) begin
      if (areset) begin
         off_r         <= 16'd0;
         hdr_r         <= 56'd0;
         exp_pid_r     <= 24'd0;
         in_block_r    <= 1'b0;
         sof_pending_r <= 1'b0;
         hsize         <= 16'd0;
         vsize         <= 16'd0;
         timestamp     <= 64'd0;
         pixel_type    <= 32'd0;
         block_id      <= 16'd0;
         meta_valid    <= 1'b0;
         frame_done    <= 1'b0;
         err           <= 1'b0;
         err_code      <= 4'd0;
      end else begin
         meta_valid <= meta_s;
         frame_done <= done_s;
         err        <= |code_s;
         err_code   <= code_s;
         if (beat_s) begin
            off_r <= s_axis_tlast ? 16'd0 : off_r + 16'd1;
            hdr_r <= {hdr_r[47:0], s_axis_tdata};
         end
         if (beat_s && (state_r == ST_LEADER)) begin
            if (in_field(off_r, OFF_TIMESTAMP, 8)) begin
               timestamp <= {timestamp[55:0], s_axis_tdata};
            end
            if (in_field(off_r, OFF_PIXEL_TYPE, 4)) begin
               pixel_type <= {pixel_type[23:0], s_axis_tdata};
            end
            if (in_field(off_r, OFF_SIZE_X_LO16, 2)) begin
               hsize <= {hsize[7:0], s_axis_tdata};
            end
            if (in_field(off_r, OFF_SIZE_Y_LO16, 2)) begin
               vsize <= {vsize[7:0], s_axis_tdata};
            end
         end
         if (leader_start_s) begin
            block_id <= hdr_s.blk;
         end
         if (accept_pkt_s) begin
            exp_pid_r <= hdr_s.pid + 24'd1;
         end
         if (meta_s) begin
            in_block_r <= 1'b1;
         end else if (leader_start_s || block_clr_s) begin
            in_block_r <= 1'b0;
         end
         if (meta_s) begin
            sof_pending_r <= 1'b1;
         end else if (pk_load_s) begin
            sof_pending_r <= 1'b0;
         end
      end
   end

   gvsp_byte_packer #(.DATA_BITS(DATA_BITS)) u_packer (
      .aclk       (aclk),
      .areset     (areset),
      .byte_data  (s_axis_tdata),
      .byte_valid (pk_valid_s),
      .byte_last  (s_axis_tlast),
      .byte_sof   (sof_pending_r),
      .byte_ready (pk_ready_s),
      .word_load  (pk_load_s),
      .m_tdata    (m_axis_tdata),
      .m_tvalid   (m_axis_tvalid),
      .m_tlast    (m_axis_tlast),
      .m_tuser    (m_axis_tuser),
      .m_tready   (m_axis_tready)
   );

endmodule
